// File: rtl/branch_target_predictor_if.sv
// Lookup/update/invalidate bundle between the IF/ID stages and branch_target_predictor.
// Statistics outputs are present only when BTP_STATS_EN is defined.
interface branch_target_predictor_if #(
  parameter int WORD_WIDTH = 16
) ();
  logic [WORD_WIDTH-1:0] read_pc;
  logic                  predict_taken;
  logic [WORD_WIDTH-1:0] predict_target;
  logic                  update_valid;
  logic [WORD_WIDTH-1:0] update_pc;
  logic [WORD_WIDTH-1:0] update_target;
  logic                  update_taken;
  logic                  update_is_jump;
  logic                  invalidate;
  logic                  busy;
`ifdef BTP_STATS_EN
  logic [31:0]           stat_lookups;
  logic [31:0]           stat_hits;
  logic [31:0]           stat_mispredicts;

  modport slave (
    input  read_pc, update_valid, update_pc, update_target, update_taken,
           update_is_jump, invalidate,
    output predict_taken, predict_target, busy,
           stat_lookups, stat_hits, stat_mispredicts
  );
  modport master (
    output read_pc, update_valid, update_pc, update_target, update_taken,
           update_is_jump, invalidate,
    input  predict_taken, predict_target, busy,
           stat_lookups, stat_hits, stat_mispredicts
  );
`else
  modport slave (
    input  read_pc, update_valid, update_pc, update_target, update_taken,
           update_is_jump, invalidate,
    output predict_taken, predict_target, busy
  );
  modport master (
    output read_pc, update_valid, update_pc, update_target, update_taken,
           update_is_jump, invalidate,
    input  predict_taken, predict_target, busy
  );
`endif
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with saturating direction counters, jump bits and an invalidate sweep FSM.
// Define BTP_STATS_EN to add saturating lookup/hit/mispredict counters.
module branch_target_predictor #(
  parameter int WORD_WIDTH = 16,
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 8,
  parameter int CTR_BITS   = 2,
  parameter int CTR_INIT   = 2
) (
  input logic                      clk,
  input logic                      reset,
  branch_target_predictor_if.slave bus
);
  localparam int DEPTH = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0]   CTR_MAX   = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]   CTR_RST   = CTR_BITS'(CTR_INIT);
  localparam logic [INDEX_BITS-1:0] SWEEP_END = {INDEX_BITS{1'b1}};

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                  state_q;
  logic [INDEX_BITS-1:0]   sweep_q;
  logic [DEPTH-1:0]        valid_q;
  logic [TAG_BITS-1:0]     tag_q    [DEPTH];
  logic [WORD_WIDTH-1:0]   target_q [DEPTH];
  logic [CTR_BITS-1:0]     ctr_q    [DEPTH];
  logic [DEPTH-1:0]        jump_q;

  logic                    busy;
  logic [INDEX_BITS-1:0]   rd_idx, up_idx;
  logic [TAG_BITS-1:0]     rd_tag, up_tag;
  logic                    rd_hit, up_hit, up_en;

  logic                    entry_we, valid_d, jump_d;
  logic [TAG_BITS-1:0]     tag_d;
  logic [WORD_WIDTH-1:0]   target_d;
  logic [CTR_BITS-1:0]     ctr_d;

  assign busy   = (state_q == SWEEP);
  assign rd_idx = bus.read_pc[INDEX_BITS-1:0];
  assign rd_tag = bus.read_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign up_idx = bus.update_pc[INDEX_BITS-1:0];
  assign up_tag = bus.update_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];

  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && !busy;
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en  = bus.update_valid && !busy;

  assign bus.busy           = busy;
  assign bus.predict_taken  = rd_hit && (jump_q[rd_idx] || ctr_q[rd_idx][CTR_BITS-1]);
  assign bus.predict_target = rd_hit ? target_q[rd_idx] : '0;

  // A not-taken resolution of a stored jump means the entry is stale, so it is dropped.
  always_comb begin
    entry_we = 1'b0;
    valid_d  = valid_q[up_idx];
    tag_d    = tag_q[up_idx];
    target_d = target_q[up_idx];
    ctr_d    = ctr_q[up_idx];
    jump_d   = jump_q[up_idx];
    if (up_en) begin
      if (up_hit && bus.update_taken) begin
        entry_we = 1'b1;
        target_d = bus.update_target;
        jump_d   = bus.update_is_jump;
        ctr_d    = (ctr_q[up_idx] == CTR_MAX) ? CTR_MAX : ctr_q[up_idx] + CTR_BITS'(1);
      end else if (up_hit) begin
        entry_we = 1'b1;
        ctr_d    = (ctr_q[up_idx] == '0) ? '0 : ctr_q[up_idx] - CTR_BITS'(1);
        if (jump_q[up_idx]) valid_d = 1'b0;
      end else if (bus.update_taken) begin
        entry_we = 1'b1;
        valid_d  = 1'b1;
        tag_d    = up_tag;
        target_d = bus.update_target;
        jump_d   = bus.update_is_jump;
        ctr_d    = CTR_RST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (entry_we) begin
      tag_q[up_idx]    <= tag_d;
      target_q[up_idx] <= target_d;
      ctr_q[up_idx]    <= ctr_d;
      jump_q[up_idx]   <= jump_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sweep_q <= '0;
      valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (entry_we) valid_q[up_idx] <= valid_d;
          if (bus.invalidate) begin
            state_q <= SWEEP;
            sweep_q <= '0;
          end
        end
        SWEEP: begin
          valid_q[sweep_q] <= 1'b0;
          if (bus.invalidate) begin
            sweep_q <= '0;
          end else if (sweep_q == SWEEP_END) begin
            state_q <= IDLE;
          end else begin
            sweep_q <= sweep_q + INDEX_BITS'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BTP_STATS_EN
  logic [31:0]           stat_lookups_q, stat_hits_q, stat_mispredicts_q;
  logic                  up_pred_taken, mispredict;
  logic [WORD_WIDTH-1:0] up_pred_target;

  assign up_pred_taken  = up_hit && !busy && (jump_q[up_idx] || ctr_q[up_idx][CTR_BITS-1]);
  assign up_pred_target = (up_hit && !busy) ? target_q[up_idx] : '0;
  assign mispredict     = (up_pred_taken != bus.update_taken) ||
                          (bus.update_taken && (up_pred_target != bus.update_target));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups_q     <= '0;
      stat_hits_q        <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (!busy && stat_lookups_q != '1) stat_lookups_q <= stat_lookups_q + 32'd1;
      if (rd_hit && stat_hits_q != '1) stat_hits_q <= stat_hits_q + 32'd1;
      if (bus.update_valid && mispredict && stat_mispredicts_q != '1)
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign bus.stat_lookups     = stat_lookups_q;
  assign bus.stat_hits        = stat_hits_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed and randomized bench for branch_target_predictor against a table-of-ints reference model.
module tb_branch_target_predictor;
  localparam int WW    = 16;
  localparam int IB    = 8;
  localparam int TB    = 8;
  localparam int CB    = 2;
  localparam int CI    = 2;
  localparam int DEPTH = 2 ** IB;
  localparam int CMAX  = 2 ** CB - 1;
  localparam int CMSB  = 2 ** (CB - 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_target_predictor_if #(.WORD_WIDTH(WW)) bus ();

  branch_target_predictor #(
    .WORD_WIDTH(WW), .INDEX_BITS(IB), .TAG_BITS(TB), .CTR_BITS(CB), .CTR_INIT(CI)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  bit mValid [DEPTH];
  int mTag   [DEPTH];
  int mTarget[DEPTH];
  int mCtr   [DEPTH];
  bit mJump  [DEPTH];
  int busyLeft;

  int checks = 0;
  int errors = 0;
  int busyCount;
  logic sampledBusy;

  function automatic int idxOf(int pc);
    return pc % DEPTH;
  endfunction

  function automatic int tagOf(int pc);
    return (pc / DEPTH) % (2 ** TB);
  endfunction

  task automatic checkValue(string name, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
    busyLeft = 0;
  endtask

  // Model one rising edge: a sweep simply hides everything until it ends, then drops all entries.
  task automatic modelClock();
    int i, t;
    bit hit;
    if (busyLeft > 0) begin
      if (bus.invalidate) busyLeft = DEPTH;
      else begin
        busyLeft--;
        if (busyLeft == 0) for (int k = 0; k < DEPTH; k++) mValid[k] = 1'b0;
      end
    end else begin
      if (bus.update_valid) begin
        i = idxOf(int'(bus.update_pc));
        t = tagOf(int'(bus.update_pc));
        hit = mValid[i] && (mTag[i] == t);
        if (hit && bus.update_taken) begin
          mTarget[i] = int'(bus.update_target);
          mJump[i]   = bus.update_is_jump;
          mCtr[i]    = (mCtr[i] + 1 > CMAX) ? CMAX : mCtr[i] + 1;
        end else if (hit) begin
          mCtr[i] = (mCtr[i] - 1 < 0) ? 0 : mCtr[i] - 1;
          if (mJump[i]) mValid[i] = 1'b0;
        end else if (bus.update_taken) begin
          mValid[i]  = 1'b1;
          mTag[i]    = t;
          mTarget[i] = int'(bus.update_target);
          mJump[i]   = bus.update_is_jump;
          mCtr[i]    = CI;
        end
      end
      if (bus.invalidate) busyLeft = DEPTH;
    end
  endtask

  task automatic checkOutput();
    int i, t;
    bit hit;
    logic [31:0] expTaken, expTarget;
    i = idxOf(int'(bus.read_pc));
    t = tagOf(int'(bus.read_pc));
    hit = (busyLeft == 0) && mValid[i] && (mTag[i] == t);
    expTaken  = (hit && (mJump[i] || mCtr[i] >= CMSB)) ? 32'd1 : 32'd0;
    expTarget = hit ? 32'(mTarget[i]) : 32'd0;
    checkValue("model_taken", 32'(bus.predict_taken), expTaken);
    checkValue("model_target", 32'(bus.predict_target), expTarget);
    checkValue("model_busy", 32'(bus.busy), (busyLeft > 0) ? 32'd1 : 32'd0);
    sampledBusy = bus.busy;
  endtask

  task automatic applyStimulus(input logic [WW-1:0] rpc, input logic uv, input logic [WW-1:0] upc,
                               input logic [WW-1:0] ut, input logic utk, input logic uj,
                               input logic inv);
    bus.read_pc        = rpc;
    bus.update_valid   = uv;
    bus.update_pc      = upc;
    bus.update_target  = ut;
    bus.update_taken   = utk;
    bus.update_is_jump = uj;
    bus.invalidate     = inv;
  endtask

  task automatic step(input logic [WW-1:0] rpc, input logic uv, input logic [WW-1:0] upc,
                      input logic [WW-1:0] ut, input logic utk, input logic uj, input logic inv);
    applyStimulus(rpc, uv, upc, ut, utk, uj, inv);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelClock();
    #1;
  endtask

  task automatic update(input logic [WW-1:0] upc, input logic [WW-1:0] ut, input logic utk,
                        input logic uj);
    step(upc, 1'b1, upc, ut, utk, uj, 1'b0);
  endtask

  task automatic probe(string name, input logic [WW-1:0] pc, input logic expTaken,
                       input logic [WW-1:0] expTarget);
    applyStimulus(pc, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkValue({name, "_taken"}, 32'(bus.predict_taken), 32'(expTaken));
    checkValue({name, "_target"}, 32'(bus.predict_target), 32'(expTarget));
    checkOutput();
    @(posedge clk);
    modelClock();
    #1;
  endtask

  initial begin
    logic [WW-1:0] rpc, upc;
    reset = 1'b1;
    modelReset();
    applyStimulus(16'h0010, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_taken", 32'(bus.predict_taken), 32'd0);
    checkValue("reset_target", 32'(bus.predict_target), 32'd0);
    checkValue("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    probe("miss0010", 16'h0010, 1'b0, 16'h0000);
    update(16'h0010, 16'h0040, 1'b1, 1'b0);
    probe("alloc0010", 16'h0010, 1'b1, 16'h0040);

    update(16'h0010, 16'h0040, 1'b0, 1'b0);
    update(16'h0010, 16'h0040, 1'b0, 1'b0);
    probe("ctr0", 16'h0010, 1'b0, 16'h0040);
    repeat (3) update(16'h0010, 16'h0040, 1'b0, 1'b0);
    probe("ctr_floor", 16'h0010, 1'b0, 16'h0040);
    update(16'h0010, 16'h0040, 1'b1, 1'b0);
    probe("ctr1", 16'h0010, 1'b0, 16'h0040);
    update(16'h0010, 16'h0040, 1'b1, 1'b0);
    probe("ctr2", 16'h0010, 1'b1, 16'h0040);

    update(16'h0020, 16'h0100, 1'b1, 1'b1);
    probe("jump_alloc", 16'h0020, 1'b1, 16'h0100);
    update(16'h0020, 16'h0100, 1'b0, 1'b0);
    probe("jump_stale", 16'h0020, 1'b0, 16'h0000);
    update(16'h0020, 16'h0100, 1'b1, 1'b1);
    probe("jump_realloc", 16'h0020, 1'b1, 16'h0100);

    update(16'h0030, 16'h0200, 1'b1, 1'b0);
    update(16'h0030, 16'h0200, 1'b0, 1'b0);
    update(16'h0030, 16'h0200, 1'b0, 1'b0);
    probe("weak_branch", 16'h0030, 1'b0, 16'h0200);
    update(16'h0030, 16'h0300, 1'b1, 1'b1);
    probe("jump_low_ctr", 16'h0030, 1'b1, 16'h0300);

    update(16'h0110, 16'h0500, 1'b1, 1'b0);
    probe("alias_old", 16'h0010, 1'b0, 16'h0000);
    probe("alias_new", 16'h0110, 1'b1, 16'h0500);

    // Small index/tag pool so random traffic keeps hitting, aliasing and saturating.
    for (int n = 0; n < 400; n++) begin
      rpc = WW'(($urandom_range(0, 3) * DEPTH) + $urandom_range(0, 7));
      upc = WW'(($urandom_range(0, 3) * DEPTH) + $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rpc = upc;
      step(rpc, 1'($urandom_range(0, 1)), upc, WW'($urandom),
           1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 9) == 0), 1'b0);
    end

    update(16'h0040, 16'h1000, 1'b1, 1'b0);
    update(16'h0041, 16'h1100, 1'b1, 1'b0);
    update(16'h0142, 16'h1200, 1'b1, 1'b1);
    update(16'h0243, 16'h1300, 1'b1, 1'b0);
    probe("pop40", 16'h0040, 1'b1, 16'h1000);
    probe("pop243", 16'h0243, 1'b1, 16'h1300);
    step(16'h0040, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    busyCount = 0;
    for (int n = 0; n < 300; n++) begin
      upc = WW'(16'h0044 + $urandom_range(0, 3));
      step(upc, busyLeft > 0, upc, WW'($urandom), 1'b1, 1'b0, 1'b0);
      busyCount += int'(sampledBusy);
    end
    checkValue("sweep_len", 32'(busyCount), 32'd256);
    probe("swept40", 16'h0040, 1'b0, 16'h0000);
    probe("swept41", 16'h0041, 1'b0, 16'h0000);
    probe("swept142", 16'h0142, 1'b0, 16'h0000);
    probe("swept243", 16'h0243, 1'b0, 16'h0000);
    probe("ignored44", 16'h0044, 1'b0, 16'h0000);
    probe("ignored47", 16'h0047, 1'b0, 16'h0000);

    step(16'h0000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    busyCount = 0;
    for (int n = 0; n < 19; n++) begin
      step(16'h0000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      busyCount += int'(sampledBusy);
    end
    step(16'h0000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    busyCount += int'(sampledBusy);
    for (int n = 0; n < 300; n++) begin
      step(16'h0000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      busyCount += int'(sampledBusy);
    end
    checkValue("restart_len", 32'(busyCount), 32'd276);

    update(16'h0050, 16'h2000, 1'b1, 1'b0);
    update(16'h0051, 16'h2100, 1'b1, 1'b1);
    probe("pop50", 16'h0050, 1'b1, 16'h2000);
    step(16'h0050, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    repeat (10) step(16'h0050, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkValue("sweep_reset_busy", 32'(bus.busy), 32'd0);
    checkValue("sweep_reset_taken", 32'(bus.predict_taken), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    probe("post_reset50", 16'h0050, 1'b0, 16'h0000);
    probe("post_reset51", 16'h0051, 1'b0, 16'h0000);
    update(16'h0050, 16'h2200, 1'b1, 1'b0);
    probe("post_reset_alloc", 16'h0050, 1'b1, 16'h2200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
